// File: rtl/number_uart_tx.sv
// number_uart_tx
//   Serialises a latched 256-bit number onto a UART TX line (8N1, MSB byte
//   first). In raw mode it sends 32 bytes. In hex mode it sends 64 uppercase
//   ASCII hex digits followed by CR LF. Frames are sent back to back, with no
//   idle gap between them.
// Parameters
//   CLK_DIV   clk cycles per UART bit (>= 2)
//   ASCII_HEX 0: raw bytes, 1: hex characters + CR LF
// Ports
//   clk     system clock
//   reset   asynchronous active-high reset
//   start   request pulse, sampled only while idle
//   number  value to send, captured on an accepted start
//   tx      UART line, idle high
//   busy    high for the whole transfer
//   done    one-cycle pulse when the transfer completes
module number_uart_tx #(
    parameter int CLK_DIV   = 434,
    parameter bit ASCII_HEX = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [255:0] number,
    output logic         tx,
    output logic         busy,
    output logic         done
);

    localparam int          N_CHARS   = ASCII_HEX ? 66 : 32;
    localparam int          BAUD_W    = $clog2(CLK_DIV);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [6:0]  LAST_CHAR = 7'(N_CHARS - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]        state;
    logic [255:0]      shadow;
    logic [6:0]        char_idx;
    logic [2:0]        bit_cnt;
    logic [BAUD_W-1:0] baud_cnt;

    logic [7:0] cur_char;
    logic [3:0] nibble;
    logic       baud_wrap;

    assign baud_wrap = (baud_cnt == BAUD_LAST);

    // The character is selected straight from the shadow register using
    // char_idx. Inverting the index yields MSB-first order without a subtract.
    always_comb begin
        nibble   = shadow[{~char_idx[5:0], 2'b00} +: 4];
        cur_char = '0;
        if (ASCII_HEX) begin
            if (char_idx == 7'd64)
                cur_char = 8'h0D;
            else if (char_idx == 7'd65)
                cur_char = 8'h0A;
            else if (nibble < 4'd10)
                cur_char = 8'h30 + {4'h0, nibble};
            else
                cur_char = 8'h37 + {4'h0, nibble};
        end else begin
            cur_char = shadow[{~char_idx[4:0], 3'b000} +: 8];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            shadow   <= '0;
            char_idx <= '0;
            bit_cnt  <= '0;
            baud_cnt <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shadow   <= number;
                        char_idx <= '0;
                        bit_cnt  <= '0;
                        baud_cnt <= '0;
                        tx       <= 1'b0;
                        busy     <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    if (baud_wrap) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        tx       <= cur_char[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_wrap) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            tx      <= cur_char[bit_cnt + 3'd1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_wrap) begin
                        baud_cnt <= '0;
                        if (char_idx != LAST_CHAR) begin
                            char_idx <= char_idx + 7'd1;
                            tx       <= 1'b0;
                            state    <= START;
                        end else begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_number_uart_tx.sv
// tb_number_uart_tx
//   Directed bench for number_uart_tx at CLK_DIV=4. One instance runs in raw
//   mode and one in hex mode.
module tb_number_uart_tx;

    localparam int DIV   = 4;
    localparam int FRAME = 10 * DIV;
    localparam int HMAX  = 2700;

    logic         clk = 1'b0;
    logic         reset;
    logic         start_r, start_h;
    logic [255:0] number;
    logic         tx_r, busy_r, done_r;
    logic         tx_h, busy_h, done_h;

    always #5 clk = ~clk;

    number_uart_tx #(.CLK_DIV(DIV), .ASCII_HEX(1'b0)) dut_raw (
        .clk(clk), .reset(reset), .start(start_r), .number(number),
        .tx(tx_r), .busy(busy_r), .done(done_r)
    );

    number_uart_tx #(.CLK_DIV(DIV), .ASCII_HEX(1'b1)) dut_hex (
        .clk(clk), .reset(reset), .start(start_h), .number(number),
        .tx(tx_h), .busy(busy_h), .done(done_h)
    );

    int checks = 0;
    int errors = 0;

    logic hist_tx   [0:HMAX-1];
    logic hist_busy [0:HMAX-1];
    logic hist_done [0:HMAX-1];

    typedef struct {
        logic [7:0] data;   // leading byte / nibble of number
        logic [9:0] frame;  // bit p = tx level during bit slot p (0 = start)
    } vec_t;

    vec_t raw_vec [5];
    vec_t hex_vec [4];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic kick(input bit hex);
        @(negedge clk);
        if (hex) start_h = 1'b1;
        else     start_r = 1'b1;
    endtask

    // Sample j is taken on the falling edge after posedge E0+j.
    task automatic capture(input bit hex, input int n, input bit t4);
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            if (j == 0) begin
                start_r = 1'b0;
                start_h = 1'b0;
            end
            hist_tx[j]   = hex ? tx_h   : tx_r;
            hist_busy[j] = hex ? busy_h : busy_r;
            hist_done[j] = hex ? done_h : done_r;
            if (t4) begin
                if (j == 50)   number  = ~number;
                if (j == 99)   start_r = 1'b1;
                if (j == 100)  start_r = 1'b0;
                if (j == 1278) start_r = 1'b1;
                if (j == 1281) start_r = 1'b0;
            end
        end
    endtask

    task automatic abort(input bit hex, input bit wait_edge, input string name);
        if (wait_edge) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk({name, "_tx"},   hex ? tx_h : tx_r, 1'b1);
        chk({name, "_busy"}, hex ? busy_h : busy_r, 1'b0);
        reset = 1'b0;
    endtask

    function automatic logic [7:0] dec(input int k);
        logic [7:0] d;
        for (int b = 0; b < 8; b++) d[b] = hist_tx[k*FRAME + (b+1)*DIV + 2];
        return d;
    endfunction

    function automatic int bad_frames(input int n);
        int bad = 0;
        for (int k = 0; k < n; k++)
            if (hist_tx[k*FRAME + 2] !== 1'b0 || hist_tx[k*FRAME + 9*DIV + 2] !== 1'b1) bad++;
        return bad;
    endfunction

    function automatic int count_high(input bit which_done, input int n);
        int c = 0;
        for (int j = 0; j < n; j++)
            if ((which_done ? hist_done[j] : hist_busy[j]) === 1'b1) c++;
        return c;
    endfunction

    function automatic logic [39:0] first_frame_act();
        logic [39:0] a;
        for (int j = 0; j < FRAME; j++) a[j] = hist_tx[j];
        return a;
    endfunction

    function automatic logic [39:0] expand(input logic [9:0] f);
        logic [39:0] e;
        for (int j = 0; j < FRAME; j++) e[j] = f[j / DIV];
        return e;
    endfunction

    function automatic logic [7:0] hexc(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + {4'h0, n};
        return 8'h41 + {4'h0, n} - 8'd10;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    logic [255:0] saved, act256;
    int           bad;

    initial begin
        // Expected first frames, written out by hand, LSB first.
        raw_vec[0] = '{8'hA5, 10'b1101001010};
        raw_vec[1] = '{8'h00, 10'b1000000000};
        raw_vec[2] = '{8'hFF, 10'b1111111110};
        raw_vec[3] = '{8'h01, 10'b1000000010};
        raw_vec[4] = '{8'h80, 10'b1100000000};
        // Hex leading nibble -> first character ('0' 0x30, '9' 0x39, 'A' 0x41, 'F' 0x46)
        hex_vec[0] = '{8'h00, 10'b1001100000};
        hex_vec[1] = '{8'h09, 10'b1001110010};
        hex_vec[2] = '{8'h0A, 10'b1010000010};
        hex_vec[3] = '{8'h0F, 10'b1010001100};

        reset   = 1'b1;
        start_r = 1'b0;
        start_h = 1'b0;
        number  = '0;
        #12;
        chk("reset_tx_raw",   tx_r,   1'b1);
        chk("reset_busy_raw", busy_r, 1'b0);
        chk("reset_done_raw", done_r, 1'b0);
        chk("reset_tx_hex",   tx_h,   1'b1);
        chk("reset_busy_hex", busy_h, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // First frame of raw transfers, including T1 (0xA5)
        foreach (raw_vec[i]) begin
            number = {raw_vec[i].data, 248'(rand256())};
            kick(1'b0);
            capture(1'b0, 44, 1'b0);
            chk("raw_frame", first_frame_act(), expand(raw_vec[i].frame));
            chk("raw_next_start", hist_tx[FRAME], 1'b0);
            chk("raw_busy_frame", count_high(1'b0, 44), 44);
            abort(1'b0, 1'b1, "raw_abort");
        end

        // First character in hex mode for the digit boundaries
        foreach (hex_vec[i]) begin
            number = {hex_vec[i].data[3:0], 252'(rand256())};
            kick(1'b1);
            capture(1'b1, 44, 1'b0);
            chk("hex_frame", first_frame_act(), expand(hex_vec[i].frame));
            abort(1'b1, 1'b1, "hex_abort");
        end

        // T2 full raw transfer, with T4 interference and a T6 start at the done edge
        number = 256'h0123456789ABCDEF_FEDCBA9876543210_A55A3CC3_0F1E2D3C_4B5A6978_8796A5B4;
        saved  = number;
        kick(1'b0);
        capture(1'b0, 1290, 1'b1);
        chk("t2_busy_len", count_high(1'b0, 1281), 1280);
        chk("t2_busy_end", hist_busy[1279], 1'b1);
        chk("t2_done_count", count_high(1'b1, 1281), 1);
        chk("t2_done_edge", hist_done[1280], 1'b1);
        chk("t2_framing", bad_frames(32), 0);
        for (int k = 0; k < 32; k++) act256[255 - 8*k -: 8] = dec(k);
        chk("t2_t4_data", act256, saved);
        chk("t6_idle_at_done", hist_busy[1280], 1'b0);
        chk("t6_accept_tx", hist_tx[1281], 1'b0);
        chk("t6_accept_busy", hist_busy[1281], 1'b1);
        abort(1'b0, 1'b1, "t6_abort");

        // T3 hex full transfer
        number = {8'hA0, 248'h0};
        saved  = number;
        kick(1'b1);
        capture(1'b1, 2650, 1'b0);
        chk("t3_first_char", dec(0), 8'h41);
        bad = 0;
        for (int k = 0; k < 64; k++)
            if (dec(k) !== hexc(saved[255 - 4*k -: 4])) bad++;
        chk("t3_hex_digits", bad, 0);
        chk("t3_cr", dec(64), 8'h0D);
        chk("t3_lf", dec(65), 8'h0A);
        chk("t3_framing", bad_frames(66), 0);
        chk("t3_busy_len", count_high(1'b0, 2650), 2640);
        chk("t3_done_edge", hist_done[2640], 1'b1);
        chk("t3_done_count", count_high(1'b1, 2650), 1);

        // T5 reset between edges E0+37 and E0+38, then a fresh transfer
        number = rand256();
        kick(1'b0);
        capture(1'b0, 38, 1'b0);
        chk("t5_busy_before", hist_busy[37], 1'b1);
        abort(1'b0, 1'b0, "t5_reset");
        number = rand256();
        saved  = number;
        kick(1'b0);
        capture(1'b0, 1285, 1'b0);
        for (int k = 0; k < 32; k++) act256[255 - 8*k -: 8] = dec(k);
        chk("t5_fresh_data", act256, saved);
        chk("t5_fresh_framing", bad_frames(32), 0);
        chk("t5_fresh_busy", count_high(1'b0, 1285), 1280);
        chk("t5_fresh_done", hist_done[1280], 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
